// File: rtl/cordic_pkg.sv
// Shared definitions for the hyperbolic CORDIC sequencer and its shift map.
package cordic_pkg;
  localparam int D_DEF  = 5;
  localparam int SW_DEF = 5;
  // First k of each hyperbolic repeat segment; the repeated shifts (3, 12) live in the ROM.
  localparam int K_REP1 = 4;
  localparam int K_REP2 = 14;
  // Pipeline depth between ROM enable and ROM data.
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} state_t;
endpackage

// File: rtl/cordic_shift_map.sv
// Iteration index k to X/Y shift amount, accounting for the hyperbolic repeats.
module cordic_shift_map
  import cordic_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [D-1:0]  k,
  output logic [SW-1:0] shift
);
  localparam logic [D-1:0] REP1 = D'(K_REP1);
  localparam logic [D-1:0] REP2 = D'(K_REP2);
  localparam logic [D-1:0] ONE  = D'(1);
  localparam logic [D-1:0] TWO  = D'(2);

  always_comb begin
    shift = SW'(k);
    if (k >= REP2)      shift = SW'(k - TWO);
    else if (k >= REP1) shift = SW'(k - ONE);
  end
endmodule

// File: rtl/cordic_iter_seq.sv
// Iteration sequencer: drives LUT_Z enable/address, emits ROM-aligned shift,
// valid/last strobes and the start/done handshake.
module cordic_iter_seq
  import cordic_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [D-1:0]  N_ITER,
  output logic          BUSY,
  output logic          EN_ROM1,
  output logic [D-1:0]  ADRS,
  output logic [SW-1:0] SHIFT,
  output logic          ITER_VLD,
  output logic          LAST,
  output logic          DONE
);
  state_t          state;
  logic [D-1:0]    n_reg;
  logic [D-1:0]    k;
  logic [STAGES:0] vld_pipe;
  logic [SW-1:0]   shift_nxt;

  // vld_pipe[0] is the ROM enable; the top bit lines up with ROM read data.
  assign EN_ROM1  = vld_pipe[0];
  assign ITER_VLD = vld_pipe[STAGES];
  assign ADRS     = k;

  cordic_shift_map #(.D(D), .SW(SW)) u_shift_map (
    .k     (k),
    .shift (shift_nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      n_reg    <= '0;
      k        <= '0;
      vld_pipe <= '0;
      SHIFT    <= '0;
      LAST     <= 1'b0;
      DONE     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      LAST               <= vld_pipe[0] && (k == n_reg);
      DONE               <= 1'b0;
      if (vld_pipe[0]) SHIFT <= shift_nxt;

      // ABORT also beats a coincident START while idle.
      if (ABORT) begin
        state    <= IDLE;
        vld_pipe <= '0;
        LAST     <= 1'b0;
        BUSY     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (START) begin
            n_reg       <= N_ITER;
            k           <= '0;
            vld_pipe[0] <= 1'b1;
            BUSY        <= 1'b1;
            state       <= RUN;
          end
          RUN: begin
            if (k == n_reg) begin
              vld_pipe[0] <= 1'b0;
              state       <= DRAIN;
            end else begin
              k <= k + 1'b1;
            end
          end
          DRAIN: begin
            DONE  <= 1'b1;
            state <= DONE_S;
          end
          DONE_S: begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cordic_iter_seq.sv
// Directed bench for cordic_iter_seq with a 1-cycle-latency LUT_Z stand-in.
module tb_cordic_iter_seq;
  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       ABORT;
  logic [4:0] N_ITER;
  logic       BUSY, EN_ROM1, ITER_VLD, LAST, DONE;
  logic [4:0] ADRS, SHIFT;
  logic [7:0] rom_q;

  int checks = 0;
  int errors = 0;

  // Hand-written shift sequence for k = 0..31.
  int shift_tbl [32] = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 12, 13,
                         14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29};

  cordic_iter_seq #(.D(5), .SW(5)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .ABORT    (ABORT),
    .N_ITER   (N_ITER),
    .BUSY     (BUSY),
    .EN_ROM1  (EN_ROM1),
    .ADRS     (ADRS),
    .SHIFT    (SHIFT),
    .ITER_VLD (ITER_VLD),
    .LAST     (LAST),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  // LUT_Z stand-in: data word tags the address it was read from.
  always @(posedge CLK) if (EN_ROM1) rom_q <= {3'b101, ADRS};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    RST = 1'b0; START = 1'b0; ABORT = 1'b0; N_ITER = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({BUSY, EN_ROM1, ITER_VLD, LAST, DONE, ADRS, SHIFT} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got %b exp 0", {BUSY, EN_ROM1, ITER_VLD, LAST, DONE, ADRS, SHIFT});
    end
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({BUSY, EN_ROM1, ITER_VLD, LAST, DONE} !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_idle got %b exp 00000", {BUSY, EN_ROM1, ITER_VLD, LAST, DONE});
    end
  endtask

  task automatic test_run(input int n, input bit poke);
    logic [4:0] ef, got, es;
    @(posedge CLK); #1 START = 1'b1; N_ITER = 5'(n);
    @(posedge CLK); #1 START = 1'b0;
    for (int c = 1; c <= n + 5; c++) begin
      @(negedge CLK);
      ef  = {c <= n + 3, c <= n + 1, (c >= 2) && (c <= n + 2), c == n + 2, c == n + 3};
      got = {BUSY, EN_ROM1, ITER_VLD, LAST, DONE};
      checks++;
      if (got !== ef) begin
        errors++;
        $display("FAIL run%0d_flags c=%0d got %b exp %b (busy,en,vld,last,done)", n, c, got, ef);
      end
      if (c <= n + 1) begin
        checks++;
        if (ADRS !== 5'(c - 1)) begin
          errors++;
          $display("FAIL run%0d_adrs c=%0d got %0d exp %0d", n, c, ADRS, c - 1);
        end
      end
      if (c >= 2 && c <= n + 2) begin
        es = 5'(shift_tbl[c - 2]);
        checks++;
        if (SHIFT !== es) begin
          errors++;
          $display("FAIL run%0d_shift k=%0d got %0d exp %0d", n, c - 2, SHIFT, es);
        end
        checks++;
        if (rom_q !== {3'b101, 5'(c - 2)}) begin
          errors++;
          $display("FAIL run%0d_rom_align k=%0d got %h exp %h", n, c - 2, rom_q, {3'b101, 5'(c - 2)});
        end
      end
      if (poke && c == 2) begin START = 1'b1; N_ITER = 5'd0; end
      if (poke && c == 3) START = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [4:0] ef, got;
    int c2;
    @(posedge CLK); #1 START = 1'b1; N_ITER = 5'd15;
    @(posedge CLK); #1 START = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge CLK);
      c2 = c - 7;
      if (c <= 6)       ef = {1'b1, 1'b1, c >= 2, 1'b0, 1'b0};
      else if (c == 7)  ef = 5'd0;
      else              ef = {c2 <= 5, c2 <= 3, (c2 >= 2) && (c2 <= 4), c2 == 4, c2 == 5};
      got = {BUSY, EN_ROM1, ITER_VLD, LAST, DONE};
      checks++;
      if (got !== ef) begin
        errors++;
        $display("FAIL abort_flags c=%0d got %b exp %b", c, got, ef);
      end
      if (c <= 6 || (c >= 8 && c2 <= 3)) begin
        checks++;
        if (ADRS !== 5'(c <= 6 ? c - 1 : c2 - 1)) begin
          errors++;
          $display("FAIL abort_adrs c=%0d got %0d exp %0d", c, ADRS, c <= 6 ? c - 1 : c2 - 1);
        end
      end
      if (c == 6) ABORT = 1'b1;
      if (c == 7) begin ABORT = 1'b0; START = 1'b1; N_ITER = 5'd2; end
      if (c == 8) START = 1'b0;
    end
  endtask

  task automatic test_start_abort_idle();
    @(posedge CLK); #1 START = 1'b1; ABORT = 1'b1; N_ITER = 5'd3;
    @(posedge CLK); #1 START = 1'b0; ABORT = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      checks++;
      if ({BUSY, EN_ROM1, ITER_VLD, LAST, DONE} !== 5'd0) begin
        errors++;
        $display("FAIL start_abort_idle c=%0d got %b exp 00000", c, {BUSY, EN_ROM1, ITER_VLD, LAST, DONE});
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1 START = 1'b1; N_ITER = 5'd15;
    @(posedge CLK); #1 START = 1'b0;
    repeat (8) @(negedge CLK);
    checks++;
    if (ADRS !== 5'd7 || EN_ROM1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got adrs=%0d en=%b exp adrs=7 en=1", ADRS, EN_ROM1);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({BUSY, EN_ROM1, ITER_VLD, LAST, DONE, ADRS, SHIFT} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %b exp 0", {BUSY, EN_ROM1, ITER_VLD, LAST, DONE, ADRS, SHIFT});
    end
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      checks++;
      if ({BUSY, EN_ROM1, ITER_VLD, LAST, DONE} !== 5'd0) begin
        errors++;
        $display("FAIL reset_mid_idle c=%0d got %b exp 00000", c, {BUSY, EN_ROM1, ITER_VLD, LAST, DONE});
      end
    end
  endtask

  initial begin
    test_reset();
    test_run(15, 1'b0);
    test_run(0, 1'b0);
    test_run(31, 1'b0);
    test_run(3, 1'b1);
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    test_run(1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
